// File: rtl/axi_write_burst_gen.sv
// axi_write_burst_gen
// Issues a programmed number of fixed-length INCR write bursts on an AXI4
// master port. The data is a running count that starts at the configured seed.
// Status (busy/done/error/bursts_done) goes back to the control register slave.
// Only one burst is in flight at a time: AW, then W beats, then B.

module axi_write_burst_gen #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_BURST_LEN  = 8,
    parameter int C_M_AXI_ID_WIDTH   = 1
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [31:0]                       cfg_base_addr,
    input  logic [15:0]                       cfg_num_bursts,
    input  logic [31:0]                       cfg_seed,
    input  logic                              cfg_start,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [15:0]                       bursts_done,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    // One burst spans BURST_LEN 4-byte beats; bases are aligned to that span
    // so a power-of-two burst never straddles a 4 KB page.
    localparam int BURST_BYTES = C_M_AXI_BURST_LEN * 4;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
        ~(C_M_AXI_ADDR_WIDTH'(BURST_BYTES - 1));
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_STRIDE =
        C_M_AXI_ADDR_WIDTH'(BURST_BYTES);
    localparam logic [7:0] LAST_BEAT = 8'(C_M_AXI_BURST_LEN - 1);
    localparam logic [C_M_AXI_DATA_WIDTH-1:0] DATA_ONE = C_M_AXI_DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        RESP   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                          state_r;
    logic                            busy_r;
    logic                            done_r;
    logic                            error_r;
    logic [15:0]                     bursts_done_r;
    logic [15:0]                     num_bursts_r;
    logic [15:0]                     burst_idx_r;
    logic [7:0]                      beat_cnt_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_r;
    logic                            awvalid_r;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;
    logic                            wlast_r;
    logic                            wvalid_r;
    logic                            bready_r;

    logic                            aw_hs_s;
    logic                            w_hs_s;
    logic                            b_hs_s;
    logic                            last_burst_s;
    logic                            next_is_last_beat_s;

    // The single outstanding burst always carries ID 0, so BID carries no
    // information worth checking.
    logic                            unused_bid_s;
    assign unused_bid_s = ^M_AXI_BID;

    // Handshake and position decodes used by the sequencer.
    always_comb begin
        aw_hs_s             = awvalid_r & M_AXI_AWREADY;
        w_hs_s              = wvalid_r & M_AXI_WREADY;
        b_hs_s              = bready_r & M_AXI_BVALID;
        last_burst_s        = (burst_idx_r == (num_bursts_r - 16'd1));
        next_is_last_beat_s = ((beat_cnt_r + 8'd1) == LAST_BEAT);
    end

    // Burst sequencer: walks IDLE -> ADDR -> DATA -> RESP per burst, all outputs registered.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            bursts_done_r <= 16'd0;
            num_bursts_r  <= 16'd0;
            burst_idx_r   <= 16'd0;
            beat_cnt_r    <= 8'd0;
            awaddr_r      <= '0;
            awvalid_r     <= 1'b0;
            wdata_r       <= '0;
            wlast_r       <= 1'b0;
            wvalid_r      <= 1'b0;
            bready_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_start) begin
                        busy_r        <= 1'b1;
                        error_r       <= 1'b0;
                        bursts_done_r <= 16'd0;
                        num_bursts_r  <= cfg_num_bursts;
                        burst_idx_r   <= 16'd0;
                        beat_cnt_r    <= 8'd0;
                        awaddr_r      <= C_M_AXI_ADDR_WIDTH'(cfg_base_addr) & ALIGN_MASK;
                        wdata_r       <= C_M_AXI_DATA_WIDTH'(cfg_seed);
                        if (cfg_num_bursts == 16'd0) begin
                            state_r <= FINISH;
                        end else begin
                            awvalid_r <= 1'b1;
                            state_r   <= ADDR;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADDR: begin
                    if (aw_hs_s) begin
                        awvalid_r  <= 1'b0;
                        wvalid_r   <= 1'b1;
                        wlast_r    <= (LAST_BEAT == 8'd0);
                        beat_cnt_r <= 8'd0;
                        state_r    <= DATA;
                    end else begin
                        state_r <= ADDR;
                    end
                end
                DATA: begin
                    if (w_hs_s) begin
                        // The pattern is contiguous across bursts, so the
                        // next beat is always the previous value plus one.
                        wdata_r <= wdata_r + DATA_ONE;
                        if (wlast_r) begin
                            wvalid_r <= 1'b0;
                            wlast_r  <= 1'b0;
                            bready_r <= 1'b1;
                            state_r  <= RESP;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 8'd1;
                            wlast_r    <= next_is_last_beat_s;
                            state_r    <= DATA;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                RESP: begin
                    if (b_hs_s) begin
                        bready_r      <= 1'b0;
                        bursts_done_r <= bursts_done_r + 16'd1;
                        if (M_AXI_BRESP != 2'b00) begin
                            error_r <= 1'b1;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= FINISH;
                        end else if (last_burst_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= FINISH;
                        end else begin
                            burst_idx_r <= burst_idx_r + 16'd1;
                            awaddr_r    <= awaddr_r + BURST_STRIDE;
                            awvalid_r   <= 1'b1;
                            state_r     <= ADDR;
                        end
                    end else begin
                        state_r <= RESP;
                    end
                end
                FINISH: begin
                    // A run ended by a response has already pulsed done; only
                    // the zero-count path still has busy set here.
                    done_r  <= busy_r;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    wlast_r   <= 1'b0;
                    bready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign bursts_done   = bursts_done_r;
    assign M_AXI_AWID    = {C_M_AXI_ID_WIDTH{1'b0}};
    assign M_AXI_AWADDR  = awaddr_r;
    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
    assign M_AXI_WLAST   = wlast_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_BREADY  = bready_r;

endmodule

// File: tb/tb_axi_write_burst_gen.sv
// Bench for axi_write_burst_gen: table of run configurations plus random runs,
// a reactive AXI slave with optional random stalls, a monitor that records
// every handshake, and a reference model that builds the expected address and
// data streams directly from the burst arithmetic.

module tb_axi_write_burst_gen;

    localparam int BL = 8;
    localparam logic [15:0] NO_ERR = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cfg_base_addr = 32'd0;
    logic [15:0] cfg_num_bursts = 16'd0;
    logic [31:0] cfg_seed = 32'd0;
    logic        cfg_start = 1'b0;
    logic        busy, done, error;
    logic [15:0] bursts_done;
    logic [0:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid;
    logic        wready = 1'b0;
    logic [0:0]  bid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;

    axi_write_burst_gen #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_BURST_LEN(BL), .C_M_AXI_ID_WIDTH(1)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts),
        .cfg_seed(cfg_seed), .cfg_start(cfg_start),
        .busy(busy), .done(done), .error(error), .bursts_done(bursts_done),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
        .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Slave behaviour and monitor records
    logic        stall_en = 1'b0;
    logic [15:0] err_burst = NO_ERR;
    logic [31:0] aw_q[$];
    logic [31:0] wd_q[$];
    logic        wl_q[$];
    int          w_bursts = 0;
    int          b_hs = 0;
    int          done_cnt = 0;

    typedef struct {
        logic [31:0] base;
        logic [15:0] count;
        logic [31:0] seed;
        logic        stall;
        logic [15:0] err_at;
        logic        glitch;
        logic [15:0] exp_bd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_records();
        aw_q.delete();
        wd_q.delete();
        wl_q.delete();
        w_bursts = 0;
        b_hs = 0;
        done_cnt = 0;
    endtask

    // Slave: READYs and BVALID change 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_bursts > b_hs)
                bvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            else
                bvalid = 1'b0;
            bresp = (16'(b_hs) == err_burst) ? 2'b10 : 2'b00;
        end
    end

    // Monitor: on the falling edge, look at what the next rising edge will transfer.
    initial begin
        logic        aw_stall = 1'b0;
        logic        w_stall = 1'b0;
        logic [31:0] aw_prev = 32'd0;
        logic [32:0] w_prev = 33'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_stall = 1'b0;
                w_stall  = 1'b0;
            end else begin
                if (aw_stall) chk("aw_hold", {31'd0, awvalid, awaddr}, {31'd0, 1'b1, aw_prev});
                if (w_stall)  chk("w_hold", {30'd0, wvalid, wlast, wdata}, {30'd0, 1'b1, w_prev});
                if (awvalid && awready) aw_q.push_back(awaddr);
                if (wvalid && wready) begin
                    chk("aw_before_w", 64'(aw_q.size() > w_bursts), 64'd1);
                    wd_q.push_back(wdata);
                    wl_q.push_back(wlast);
                    if (wlast) w_bursts++;
                end
                if (bready && bvalid) b_hs++;
                if (done) done_cnt++;
                aw_stall = awvalid && !awready;
                w_stall  = wvalid && !wready;
                aw_prev  = awaddr;
                w_prev   = {wlast, wdata};
            end
        end
    end

    // Reference model: burst n sits at aligned_base + n*BL*4, beat k carries seed + n*BL + k.
    task automatic check_streams(input vec_t v);
        int nb;
        logic [31:0] base_al;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        nb = (v.err_at < v.count) ? int'(v.err_at) + 1 : int'(v.count);
        base_al = v.base - (v.base % (BL * 4));
        chk("aw_count", 64'(aw_q.size()), 64'(nb));
        chk("w_count", 64'(wd_q.size()), 64'(nb * BL));
        for (int n = 0; n < nb && n < aw_q.size(); n++) begin
            exp_a = base_al + 32'(n * BL * 4);
            chk($sformatf("awaddr[%0d]", n), 64'(aw_q[n]), 64'(exp_a));
        end
        for (int i = 0; i < nb * BL && i < wd_q.size(); i++) begin
            exp_d = v.seed + 32'(i);
            chk($sformatf("wdata[%0d]", i), 64'(wd_q[i]), 64'(exp_d));
            chk($sformatf("wlast[%0d]", i), 64'(wl_q[i]), 64'((i % BL) == BL - 1));
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c;
        stall_en  = v.stall;
        err_burst = v.err_at;
        clear_records();
        cfg_base_addr  = v.base;
        cfg_num_bursts = v.count;
        cfg_seed       = v.seed;
        cfg_start      = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk($sformatf("v%0d busy_after_start", idx), 64'(busy), 64'd1);
        chk($sformatf("v%0d awvalid_after_start", idx), 64'(awvalid), 64'(v.count != 16'd0));
        chk($sformatf("v%0d error_cleared", idx), 64'(error), 64'd0);
        chk($sformatf("v%0d bursts_done_cleared", idx), 64'(bursts_done), 64'd0);
        if (v.glitch) begin
            repeat (5) tick();
            cfg_base_addr  = 32'hDEAD0000;
            cfg_num_bursts = 16'd9;
            cfg_seed       = 32'h55555555;
            cfg_start      = 1'b1;
            tick();
            cfg_start = 1'b0;
        end
        c = 0;
        while (done_cnt == 0 && c < 3000) begin
            tick();
            c++;
        end
        chk($sformatf("v%0d done_timeout", idx), 64'(done_cnt != 0), 64'd1);
        repeat (3) tick();
        chk($sformatf("v%0d done_pulses", idx), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d busy_end", idx), 64'(busy), 64'd0);
        chk($sformatf("v%0d bursts_done", idx), 64'(bursts_done), 64'(v.exp_bd));
        chk($sformatf("v%0d error", idx), 64'(error), 64'(v.exp_err));
        check_streams(v);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int c;

        // Directed table: base, count, seed, stall, err_at, glitch, exp_bd, exp_err
        vecs.push_back('{32'h00001000, 16'd4, 32'h00000001, 1'b0, NO_ERR, 1'b0, 16'd4, 1'b0});
        vecs.push_back('{32'h00001007, 16'd1, 32'h00000100, 1'b0, NO_ERR, 1'b0, 16'd1, 1'b0});
        vecs.push_back('{32'h00003000, 16'd3, 32'hDEAD0000, 1'b1, NO_ERR, 1'b0, 16'd3, 1'b0});
        vecs.push_back('{32'h00001000, 16'd4, 32'h00000007, 1'b0, 16'd1,  1'b0, 16'd2, 1'b1});
        vecs.push_back('{32'h00004000, 16'd2, 32'h00000009, 1'b0, NO_ERR, 1'b0, 16'd2, 1'b0});
        vecs.push_back('{32'h00000000, 16'd1, 32'hFFFFFFFC, 1'b0, NO_ERR, 1'b0, 16'd1, 1'b0});
        vecs.push_back('{32'hFFFFFFE4, 16'd2, 32'h00000003, 1'b1, NO_ERR, 1'b0, 16'd2, 1'b0});
        vecs.push_back('{32'h00002000, 16'd3, 32'h00000010, 1'b0, NO_ERR, 1'b1, 16'd3, 1'b0});
        vecs.push_back('{32'h00006000, 16'd3, 32'h00000020, 1'b1, 16'd2,  1'b0, 16'd3, 1'b1});
        // Random runs; expectations follow from the count and error position.
        for (int r = 0; r < 6; r++) begin
            v.base    = $urandom;
            v.count   = 16'($urandom_range(1, 5));
            v.seed    = $urandom;
            v.stall   = 1'($urandom_range(0, 1));
            v.err_at  = 16'($urandom_range(0, 7));
            v.glitch  = 1'b0;
            v.exp_err = (v.err_at < v.count);
            v.exp_bd  = v.exp_err ? v.err_at + 16'd1 : v.count;
            vecs.push_back(v);
        end

        // Reset state
        repeat (3) tick();
        chk("rst awvalid", 64'(awvalid), 64'd0);
        chk("rst wvalid", 64'(wvalid), 64'd0);
        chk("rst bready", 64'(bready), 64'd0);
        chk("rst busy_done_error", 64'({busy, done, error}), 64'd0);
        chk("rst bursts_done", 64'(bursts_done), 64'd0);
        chk("rst awaddr_wdata_wlast", 64'({awaddr, wlast}), 64'd0);
        chk("const awlen", 64'(awlen), 64'(BL - 1));
        chk("const awsize_awburst", 64'({awsize, awburst}), 64'b010_01);
        chk("const wstrb_awid", 64'({wstrb, awid}), 64'b1111_0);
        rst_n = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Zero count: done at the second edge after start, AWVALID never rises.
        stall_en = 1'b0;
        err_burst = NO_ERR;
        clear_records();
        cfg_num_bursts = 16'd0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("zero t+1 done", 64'(done), 64'd0);
        chk("zero t+1 busy", 64'(busy), 64'd1);
        chk("zero t+1 awvalid", 64'(awvalid), 64'd0);
        tick();
        chk("zero t+2 done", 64'(done), 64'd1);
        chk("zero t+2 busy", 64'(busy), 64'd0);
        tick();
        chk("zero t+3 done", 64'(done), 64'd0);
        repeat (2) tick();
        chk("zero no aw", 64'(aw_q.size()), 64'd0);
        chk("zero done count", 64'(done_cnt), 64'd1);

        // Reset during the data phase, then a clean run.
        clear_records();
        cfg_base_addr = 32'h00005000;
        cfg_num_bursts = 16'd2;
        cfg_seed = 32'h00000100;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        c = 0;
        while (!(wvalid && wd_q.size() >= 2) && c < 200) begin
            tick();
            c++;
        end
        chk("mid reset reached data", 64'(wvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset valids", 64'({awvalid, wvalid, bready}), 64'd0);
        chk("mid reset busy", 64'(busy), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mid reset no done", 64'(done_cnt), 64'd0);
        run_vec(vecs[0], 99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_write_burst_gen.md
# axi_write_burst_gen

AXI4 (full) write-burst generator that sits directly downstream of the `axi_write` AXI4-Lite control register slave. It consumes the slave's configuration registers (base address, burst count, data seed, start) and issues a sequence of fixed-length INCR write bursts with a deterministic data pattern onto an AXI4 memory-mapped master port. Status (busy, done, error, progress count) is returned to the register slave for software readback.

## Interface
Parameters:
- `C_M_AXI_ADDR_WIDTH`, 32, AWADDR width
- `C_M_AXI_DATA_WIDTH`, 32, WDATA width; only 32 supported
- `C_M_AXI_BURST_LEN`, 8, beats per burst; power of two, 1..256
- `C_M_AXI_ID_WIDTH`, 1, AWID/BID width

Ports:
- `ACLK` in 1: single clock for all logic
- `ARESETN` in 1: asynchronous active-low reset
- `cfg_base_addr` in 32: byte address of first burst
- `cfg_num_bursts` in 16: number of bursts to issue
- `cfg_seed` in 32: data value of first beat
- `cfg_start` in 1: one-cycle start pulse
- `busy` out 1: high from accepted start until done
- `done` out 1: one-cycle completion pulse
- `error` out 1: sticky non-OKAY BRESP seen; cleared on next accepted start
- `bursts_done` out 16: bursts completed with response in current run
- `M_AXI_AWID` out ID_WIDTH, `M_AXI_AWADDR` out ADDR_WIDTH, `M_AXI_AWLEN` out 8, `M_AXI_AWSIZE` out 3, `M_AXI_AWBURST` out 2, `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1
- `M_AXI_WDATA` out 32, `M_AXI_WSTRB` out 4, `M_AXI_WLAST` out 1, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1
- `M_AXI_BID` in ID_WIDTH, `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1

## Operation
- Constants: AWID=0, AWLEN=BURST_LEN-1, AWSIZE=3'b010, AWBURST=INCR, WSTRB=4'hF.
- FSM states: IDLE, ADDR, DATA, RESP, FINISH.
- IDLE: on `cfg_start`, latch all cfg inputs; clear `error` and `bursts_done`; set `busy`. If latched count = 0, go to FINISH; otherwise go to ADDR.
- `cfg_start` is ignored while `busy` is high.
- ADDR: assert AWVALID with AWADDR = base_aligned + n*BURST_LEN*4, where n is the burst index from 0. base_aligned = cfg_base_addr with its low log2(BURST_LEN*4) bits forced to 0, so no burst crosses a 4 KB boundary. Address arithmetic wraps modulo 2^ADDR_WIDTH. On AWREADY go to DATA.
- DATA: assert WVALID. Beat k of burst n carries seed + n*BURST_LEN + k, modulo 2^32. WLAST is high on beat BURST_LEN-1. On the WLAST handshake go to RESP.
- RESP: assert BREADY. On BVALID, increment `bursts_done`. If BRESP != 2'b00, set `error` and go to FINISH (abort the remaining bursts). Otherwise, if this was the last burst go to FINISH, else go to ADDR with n+1.
- FINISH: pulse `done` for one cycle, clear `busy`, return to IDLE.
- Only one burst is outstanding at a time. The AW handshake always completes before any W beat.

## Timing
- All outputs reset to 0 except the constant AWLEN/AWSIZE/AWBURST/WSTRB fields.
- Reset mid-run: AWVALID, WVALID and BREADY drop asynchronously. The FSM returns to IDLE and no `done` pulse is generated.
- Start latency: `cfg_start` high at edge t gives AWVALID high from t+1.
- AWVALID/AWADDR and WVALID/WDATA/WLAST stay stable until their READY is sampled high; VALID never depends on READY.
- WVALID rises the cycle after the AW handshake. With WREADY held high, one beat is transferred per cycle, so a burst takes BURST_LEN cycles.
- BREADY rises the cycle after the WLAST handshake.
- `done` pulses, and `busy` falls, one cycle after the final B handshake. With a zero count, `done` occurs at t+2.
- `bursts_done` updates the cycle after each B handshake.

## Test plan
- Base 0x1000, count 4, seed 1, all READY high: 4 bursts at 0x1000/0x1020/0x1040/0x1060. Data runs 1..32 with WLAST on every 8th beat. `done` pulses once, `bursts_done`=4, `error`=0.
- Base 0x1007: first AWADDR is 0x1000. Count 0: `done` pulses at t+2 and AWVALID never asserts.
- Randomised AWREADY/WREADY/BVALID stalls, count 3: VALID and payload stay stable under every stall and the data sequence is unchanged. Bursts 1..3 end with `bursts_done`=3.
- BRESP=SLVERR on burst 2 of 4: `error`=1, `bursts_done`=2, no third AW, `done` pulses. The next start clears `error`.
- `cfg_start` pulsed again mid-run: the pulse is ignored and the run completes with its original config. ARESETN asserted mid-DATA: all VALIDs low immediately and a fresh start after release runs correctly.
- Seed 0xFFFFFFFC, count 1: data is FFFFFFFC, FFFFFFFD, FFFFFFFE, FFFFFFFF, 0, 1, 2, 3 (wraps modulo 2^32).
